// File: rtl/uart_led_monitor_if.sv
// uart_led_monitor_if: serial line in, LED status bus out.
//   rxd     - raw asynchronous serial line, idle high
//   ledsOut - 16-bit registered status bus
interface uart_led_monitor_if;
    logic        rxd;
    logic [15:0] ledsOut;
    modport master (output rxd, input ledsOut);
    modport slave  (input rxd, output ledsOut);
endinterface

// File: rtl/uart_led_monitor.sv
// uart_led_monitor: 7E1 serial receiver driving an LED status bus.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - rxd in; ledsOut = {count[4:0], 0, busy, frame_err, parity_err, data[6:0]}
module uart_led_monitor #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic              clk,
    input  logic              reset,
    uart_led_monitor_if.slave bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
    state_t        state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [6:0]    shift;
    logic          par_bit;
    logic [15:0]   leds;
    logic          rx;
    logic          tick_half;
    logic          tick_full;
    logic          par_bad;
    assign rx          = sync[1];
    assign tick_half   = cnt == CW'(HALF - 1);
    assign tick_full   = cnt == CW'(CLKS_PER_BIT - 1);
    assign par_bad     = ^{shift, par_bit};
    assign bus.ledsOut = leds;
    // leds[10] is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sync    <= 2'b11;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            leds    <= '0;
        end else begin
            sync <= {sync[0], bus.rxd};
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx) begin
                        state   <= START;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    cnt <= tick_half ? '0 : cnt + 1'b1;
                    if (tick_half) begin
                        state   <= rx ? IDLE : DATA;
                        leds[9] <= !rx;
                    end
                end
                DATA: begin
                    cnt <= tick_full ? '0 : cnt + 1'b1;
                    if (tick_full) begin
                        shift[bit_idx] <= rx;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd6) state <= PARITY;
                    end
                end
                PARITY: begin
                    cnt <= tick_full ? '0 : cnt + 1'b1;
                    if (tick_full) begin
                        par_bit <= rx;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    cnt <= tick_full ? '0 : cnt + 1'b1;
                    if (tick_full) begin
                        leds[9] <= 1'b0;
                        if (!rx) begin
                            state     <= WAIT_IDLE;
                            leds[8:7] <= {1'b1, par_bad};
                        end else begin
                            state     <= IDLE;
                            leds[8:7] <= {1'b0, par_bad};
                            if (!par_bad) begin
                                leds[6:0]   <= shift;
                                leds[15:11] <= (&leds[15:11]) ? leds[15:11] : leds[15:11] + 5'd1;
                            end
                        end
                    end
                end
                WAIT_IDLE: if (rx) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_led_monitor.sv
// tb_uart_led_monitor: directed frames against the LED status bus.
module tb_uart_led_monitor;
    localparam int CPB = 16;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy_seen;
    int checks = 0;
    int failures = 0;
    logic [6:0]  burst_data [11] = '{7'h66, 7'h54, 7'h27, 7'h1A, 7'h07, 7'h7C, 7'h14, 7'h4C, 7'h33, 7'h3F, 7'h06};
    logic [15:0] burst_exp  [11] = '{16'h0866, 16'h1054, 16'h1827, 16'h201A, 16'h2807, 16'h307C,
                                     16'h3814, 16'h404C, 16'h4833, 16'h503F, 16'h5806};
    always #5 clk = ~clk;
    uart_led_monitor_if bus ();
    uart_led_monitor #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Line order: start, d0..d6, even parity (optionally flipped), stop.
    function automatic logic [9:0] frame(input logic [6:0] d, input logic pflip, input logic stop);
        return {stop, (^d) ^ pflip, d, 1'b0};
    endfunction

    task automatic send(input logic [9:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.rxd = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [6:0] d, input logic pflip, input logic stop);
        send(frame(d, pflip, stop), 0, 9);
    endtask

    task automatic pulse_reset;
        reset = 1'b0;
        #1;
        check("rst_now", bus.ledsOut, 16'h0000);
        @(posedge clk);
        #1;
        bus.rxd = 1'b1;
        reset = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.rxd = 1'b1;
        #200;
        check("reset", bus.ledsOut, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle", bus.ledsOut, 16'h0000);

        bus.rxd = 1'b0;
        busy_seen = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.rxd = 1'b1;
        repeat (3 * CPB) begin
            @(posedge clk);
            #1;
            if (bus.ledsOut[9]) busy_seen = 1'b1;
        end
        check("glitch_busy", {15'b0, busy_seen}, 16'h0000);
        check("glitch_leds", bus.ledsOut, 16'h0000);

        send(frame(7'h66, 1'b0, 1'b1), 0, 4);
        check("busy", {15'b0, bus.ledsOut[9]}, 16'h0001);
        send(frame(7'h66, 1'b0, 1'b1), 5, 9);
        check("single", bus.ledsOut, 16'h0866);

        send_frame(7'h66, 1'b1, 1'b1);
        check("par_err", bus.ledsOut, 16'h08E6);
        send_frame(7'h66, 1'b0, 1'b0);
        repeat (3 * CPB) @(posedge clk);
        #1;
        check("frm_err", bus.ledsOut, 16'h0966);
        bus.rxd = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        send_frame(7'h54, 1'b0, 1'b1);
        check("clear", bus.ledsOut, 16'h1054);

        send(frame(7'h27, 1'b0, 1'b1), 0, 4);
        check("busy_mid", {15'b0, bus.ledsOut[9]}, 16'h0001);
        pulse_reset();
        send_frame(7'h27, 1'b0, 1'b1);
        check("after_rst", bus.ledsOut, 16'h0827);

        pulse_reset();
        for (int i = 0; i < 11; i++) begin
            send_frame(burst_data[i], 1'b0, 1'b1);
            check($sformatf("burst%0d", i), bus.ledsOut, burst_exp[i]);
        end

        for (int i = 0; i < 21; i++) begin
            send_frame(7'h55, 1'b0, 1'b1);
            if (i == 18) check("count30", bus.ledsOut, 16'hF055);
        end
        check("saturate", bus.ledsOut, 16'hF855);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
